// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit seven-segment scan driver with frame-aligned double buffering
module seg_scan_driver #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_en,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        err
);

  logic [3:0]  prev_en;
  logic [15:0] pend_data, act_data, disp_data;
  logic [3:0]  pend_dp, act_dp, disp_dp;
  logic        boundary, commit, one_hot, legal, blank;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic [6:0]  seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Decode from the value being committed so the whole new frame shows it.
  always_comb begin
    boundary  = (digit_en == 4'b1110) && (prev_en == 4'b0111);
    commit    = boundary && busy;
    disp_data = commit ? pend_data : act_data;
    disp_dp   = commit ? pend_dp : act_dp;
    one_hot   = 1'b1;
    idx       = 2'd0;
    case (digit_en)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
    legal = one_hot || (digit_en == 4'b1111);
    nib   = disp_data[{idx, 2'b00} +: 4];
    case (idx)
      2'd3:    blank = (disp_data[15:12] == 4'h0);
      2'd2:    blank = (disp_data[15:8] == 8'h00);
      2'd1:    blank = (disp_data[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
    blank    = blank && BLANK_LZ;
    seg_next = blank ? 7'h7F : hex7(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_en   <= 4'b1111;
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      prev_en <= digit_en;
      if (!legal) err <= 1'b1;
      if (commit) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        busy     <= 1'b0;
      end else if (wr_en && !busy) begin
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
        busy      <= 1'b1;
      end
      if (one_hot) begin
        an  <= digit_en;
        seg <= seg_next;
        dp  <= ~disp_dp[idx];
      end else begin
        an  <= 4'b1111;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized and directed bench for seg_scan_driver
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        busy, dp, err, busy0, dp0, err0;
  logic [3:0]  an, an0;
  logic [6:0]  seg, seg0;

  int checks = 0;
  int failures = 0;

  seg_scan_driver #(.BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .digit_en(digit_en), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dp(wr_dp), .busy(busy), .an(an), .seg(seg), .dp(dp), .err(err));

  seg_scan_driver #(.BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .digit_en(digit_en), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dp(wr_dp), .busy(busy0), .an(an0), .seg(seg0), .dp(dp0), .err(err0));

  always #5 clk = ~clk;

  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [3:0] scan [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Reference state: what was last written, what is on screen, last strobe seen.
  logic [3:0]  m_prev;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  logic        m_busy, m_err;
  logic [3:0]  e_an;
  logic [6:0]  e_seg, e_seg0;
  logic        e_dp;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 4'hF; m_pend = 0; m_act = 0; m_pdp = 0; m_adp = 0;
    m_busy = 0; m_err = 0; e_an = 4'hF; e_seg = 7'h7F; e_seg0 = 7'h7F; e_dp = 1;
  endtask

  task automatic model_step(input logic [3:0] en, input logic we, input logic [15:0] wd,
                            input logic [3:0] wdp);
    int d;
    logic [15:0] show;
    logic [3:0] show_dp;
    logic do_commit;
    d = -1;
    for (int i = 0; i < 4; i++) if (en == scan[i]) d = i;
    do_commit = (en == 4'b1110) && (m_prev == 4'b0111) && m_busy;
    show    = do_commit ? m_pend : m_act;
    show_dp = do_commit ? m_pdp : m_adp;
    if (d >= 0) begin
      e_an   = en;
      e_seg0 = font[(show >> (4 * d)) & 16'hF];
      e_seg  = (d > 0 && int'(show) < (1 << (4 * d))) ? 7'h7F : e_seg0;
      e_dp   = !show_dp[d];
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_seg0 = 7'h7F; e_dp = 1;
      if (en != 4'hF) m_err = 1;
    end
    if (do_commit) begin
      m_act = m_pend; m_adp = m_pdp; m_busy = 0;
    end else if (we && !m_busy) begin
      m_pend = wd; m_pdp = wdp; m_busy = 1;
    end
    m_prev = en;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".an"}, {12'h0, an}, {12'h0, e_an});
    chk({tag, ".seg"}, {9'h0, seg}, {9'h0, e_seg});
    chk({tag, ".dp"}, {15'h0, dp}, {15'h0, e_dp});
    chk({tag, ".busy"}, {15'h0, busy}, {15'h0, m_busy});
    chk({tag, ".err"}, {15'h0, err}, {15'h0, m_err});
    chk({tag, ".seg0"}, {9'h0, seg0}, {9'h0, e_seg0});
    chk({tag, ".an0"}, {12'h0, an0}, {12'h0, e_an});
  endtask

  task automatic cycle(input string tag, input logic [3:0] en, input logic we = 1'b0,
                       input logic [15:0] wd = 16'h0, input logic [3:0] wdp = 4'h0);
    @(negedge clk);
    digit_en = en; wr_en = we; wr_data = wd; wr_dp = wdp;
    @(posedge clk);
    model_step(en, we, wd, wdp);
    #1;
    check_all(tag);
  endtask

  task automatic frame(input string tag);
    for (int i = 0; i < 4; i++) cycle(tag, scan[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; digit_en = 4'hF; wr_en = 0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; digit_en = 4'hF; wr_en = 0; wr_data = 0; wr_dp = 0;
    model_reset();
    #12;
    check_all("reset");
    rst = 0;

    // Case 1: idle display after reset
    for (int f = 0; f < 4; f++) frame("c1");
    cycle("c1", 4'b1110);
    chk("c1_d0_zero", {9'h0, seg}, {9'h0, 7'b1000000});

    // Case 2: write mid-frame, visible from next frame
    cycle("c2", 4'b1101, 1'b1, 16'h12AF, 4'b0100);
    cycle("c2", 4'b1011);
    chk("c2_busy", {15'h0, busy}, 16'h1);
    cycle("c2", 4'b0111);
    frame("c2");
    chk("c2_busy_clr", {15'h0, busy}, 16'h0);
    cycle("c2", 4'b1110);
    cycle("c2", 4'b1101);
    cycle("c2", 4'b1011);
    chk("c2_d2_dp", {15'h0, dp}, 16'h0);
    cycle("c2", 4'b0111);
    chk("c2_d3_seg", {9'h0, seg}, {9'h0, 7'b1111001});

    // Case 3/4: blanked write, then a discarded write while busy
    cycle("c3", 4'b1110, 1'b1, 16'h0005, 4'b0000);
    cycle("c4", 4'b1101, 1'b1, 16'hFFFF, 4'b1111);
    cycle("c4", 4'b1011);
    cycle("c4", 4'b0111);
    for (int f = 0; f < 2; f++) frame("c3");
    cycle("c3", 4'b1110);
    chk("c3_d0", {9'h0, seg}, {9'h0, 7'b0010010});
    cycle("c3", 4'b1101);
    chk("c3_d1_blank", {9'h0, seg}, 16'h7F);
    chk("c3_d1_noblank", {9'h0, seg0}, {9'h0, 7'b1000000});

    // Constant strobe: no boundary; boundary+write with busy=0 defers commit
    for (int i = 0; i < 5; i++) cycle("hold", 4'b1110);
    cycle("hold", 4'b0111);
    cycle("bw", 4'b1110, 1'b1, 16'h4321, 4'b0001);
    frame("bw");
    frame("bw");

    // Case 5: illegal strobe sets sticky err
    cycle("c5", 4'b1100);
    chk("c5_err", {15'h0, err}, 16'h1);
    chk("c5_an", {12'h0, an}, 16'hF);
    frame("c5");
    frame("c5");

    // Case 6: reset while busy drops pending
    cycle("c6", 4'b1110);
    cycle("c6", 4'b1101, 1'b1, 16'h8888, 4'b1111);
    do_reset();
    for (int f = 0; f < 2; f++) frame("c6");
    chk("c6_err_clr", {15'h0, err}, 16'h0);

    // Randomized scanning with occasional bad strobes and writes
    begin
      int r;
      logic [3:0] en;
      r = 0;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 29) == 0) en = 4'($urandom);
        else if ($urandom_range(0, 19) == 0) en = 4'hF;
        else begin
          en = scan[r];
          r = (r + 1) % 4;
        end
        cycle("rand", en, ($urandom_range(0, 7) == 0), 16'($urandom),
              4'($urandom));
        if (n == 300) do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
